sysref_lmfc_align: RTL and testbench
====================================

# sysref_lmfc_align

Downstream consumer of the periodic SYSREF pulse train in the JESD204B receive path. Detects SYSREF rising edges, phase-aligns a local LMFC counter to the first edge, then checks every later edge against the running LMFC boundary. Drives the LMFC boundary pulse, alignment status and error statistics to the link layer and CSR block.

## Interface
- F, 4, octets per frame; LMFC period P = K*F/4 clocks (4 octets/clock).
- K, 32, frames per multiframe; P must satisfy 2 ≤ P ≤ 512.
- ERR_THRESH, 3, consecutive misaligned edges that drop alignment when realign_en=0; range 1..15.
- clock  in  1  link clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- sysref  in  1  SYSREF, synchronous to clock, pulse width ≥1 cycle.
- realign_en  in  1  1: a misaligned edge reloads the LMFC phase; 0: it is only flagged.
- clr_err  in  1  synchronous clear of err_cnt and the consecutive-miss counter.
- lmfc_cnt  out  9  LMFC phase, 0..P-1.
- lmfc_pulse  out  1  high for the one cycle in which lmfc_cnt==0 while aligned.
- aligned  out  1  high in ALIGNED state.
- sysref_err  out  1  one-cycle pulse per misaligned edge.
- err_cnt  out  8  saturating count of misaligned edges.

## Operation
- Edge detect: sysref_q <= sysref; edge = sysref & ~sysref_q. Level-held SYSREF gives exactly one edge.
- States: IDLE, ALIGNED.
- IDLE: lmfc_cnt held 0, lmfc_pulse 0, aligned 0. On edge at cycle t -> ALIGNED, lmfc_cnt(t+1)=0, lmfc_pulse(t+1)=1. Not counted as an error.
- ALIGNED: lmfc_cnt increments, wraps P-1 -> 0; lmfc_pulse = (lmfc_cnt==0).
- Edge check in ALIGNED: edge at cycle t is aligned iff lmfc_cnt(t)==P-1 (next value is 0 either way). Aligned edge clears the consecutive-miss counter.
- Misaligned edge: sysref_err=1 at t+1; err_cnt += 1, saturating at 255; miss counter += 1.
  - realign_en=1: lmfc_cnt(t+1)=0, lmfc_pulse(t+1)=1, stay ALIGNED, miss counter cleared.
  - realign_en=0: counter keeps running; when the miss counter reaches ERR_THRESH -> IDLE at t+1 (lmfc_cnt=0, aligned=0). The next edge realigns from IDLE.
- clr_err: at the next cycle err_cnt=0 and miss counter=0. Simultaneous with a misaligned edge, clear wins for the counters; sysref_err still pulses and the realign/drop decision uses the pre-clear miss count.
- Arithmetic: P computed at elaboration as K*F/4, 9-bit; compare against P-1 constant. Elaboration error if P<2 or P>512.

## Timing
- Reset values: sysref_q=1 (SYSREF high out of reset is not an edge), state IDLE, lmfc_cnt=0, lmfc_pulse=0, aligned=0, sysref_err=0, err_cnt=0, miss counter=0.
- All outputs registered; edge-to-response latency 1 cycle (sysref high at t, low at t-1 -> reaction at t+1).
- Reset mid-operation: immediate return to reset values; no residual pulse.
- Edges closer than P cycles apart: each is checked independently.
- sysref high for P or more cycles: one edge only; no error.

## Structure
- Package jesd_lmfc_pkg: LMFC_W=9, ERR_W=8, state enum (IDLE, ALIGNED), function lmfc_period(K,F).
- Sub-module sysref_edge_det: the sysref_q register plus the rising-edge output, reset to 1. Everything else stays in the top.

## Test plan
- K=32,F=4 (P=32): edge every 32 cycles -> aligned=1 one cycle after first edge, lmfc_pulse every 32 cycles coincident with edges+1, err_cnt=0.
- Aligned, realign_en=1, one edge 5 cycles late -> sysref_err single pulse, err_cnt=1, lmfc_cnt=0 the cycle after the late edge, later edges on the new phase raise no errors.
- realign_en=0, ERR_THRESH=3, three consecutive edges offset by 1 -> err_cnt=3, aligned falls after the third; the next edge realigns.
- realign_en=0, two misaligned edges then one aligned, then two misaligned -> aligned stays 1, err_cnt=4.
- 300 misaligned edges -> err_cnt saturates at 255. clr_err coincident with a misaligned edge -> err_cnt=0, sysref_err=1.
- sysref held high across rst_n release, then held 100 cycles -> no edge and state IDLE. Assert rst_n mid-count -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/sysref_lmfc_align_pkg.sv
// Shared widths, state encoding and LMFC period helper for the SYSREF/LMFC alignment block.
package jesd_lmfc_pkg;

  localparam int LMFC_W = 9;
  localparam int ERR_W  = 8;
  localparam int MISS_W = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    ALIGNED = 1'b1
  } lmfc_state_e;

  // Four octets per link clock, so one multiframe spans K*F/4 clocks.
  function automatic int lmfc_period(input int k, input int f);
    return (k * f) / 4;
  endfunction

endpackage

// File: rtl/sysref_lmfc_align_if.sv
// Control inputs and LMFC/status outputs exchanged between the link layer/CSR side and the aligner.
interface sysref_lmfc_align_if;
  import jesd_lmfc_pkg::*;

  logic              sysref;
  logic              realign_en;
  logic              clr_err;
  logic [LMFC_W-1:0] lmfc_cnt;
  logic              lmfc_pulse;
  logic              aligned;
  logic              sysref_err;
  logic [ERR_W-1:0]  err_cnt;

  modport master (
    output sysref, realign_en, clr_err,
    input  lmfc_cnt, lmfc_pulse, aligned, sysref_err, err_cnt
  );

  modport slave (
    input  sysref, realign_en, clr_err,
    output lmfc_cnt, lmfc_pulse, aligned, sysref_err, err_cnt
  );

endinterface

// File: rtl/sysref_lmfc_align_edge_det.sv
// SYSREF rising-edge detector; the history register resets high so a SYSREF
// already asserted when reset releases is not mistaken for an edge.
module sysref_edge_det (
  input  logic clock,
  input  logic rst_n,
  input  logic sysref_i,
  output logic edge_o
);

  logic sysref_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sysref_q <= 1'b1;
    end else begin
      sysref_q <= sysref_i;
    end
  end

  assign edge_o = sysref_i & ~sysref_q;

endmodule

// File: rtl/sysref_lmfc_align.sv
// Aligns a local LMFC counter to the first SYSREF edge, checks later edges against the LMFC
// boundary, and reports alignment status and misaligned-edge statistics. All outputs registered.
module sysref_lmfc_align
  import jesd_lmfc_pkg::*;
#(
  parameter int F          = 4,
  parameter int K          = 32,
  parameter int ERR_THRESH = 3
) (
  input  logic                 clock,
  input  logic                 rst_n,
  sysref_lmfc_align_if.slave   lmfc_if
);

  localparam int P = lmfc_period(K, F);
  localparam logic [LMFC_W-1:0] P_M1   = LMFC_W'(P - 1);
  localparam logic [MISS_W:0]   THRESH = (MISS_W + 1)'(ERR_THRESH);

  if (P < 2 || P > 512) begin : g_bad_period
    $error("sysref_lmfc_align: LMFC period K*F/4 must lie in 2..512");
  end
  if (ERR_THRESH < 1 || ERR_THRESH > 15) begin : g_bad_thresh
    $error("sysref_lmfc_align: ERR_THRESH must lie in 1..15");
  end

  logic edge_det;

  sysref_edge_det u_edge_det (
    .clock    (clock),
    .rst_n    (rst_n),
    .sysref_i (lmfc_if.sysref),
    .edge_o   (edge_det)
  );

  lmfc_state_e       state_q, state_d;
  logic [LMFC_W-1:0] lmfc_cnt_q, lmfc_cnt_d;
  logic              lmfc_pulse_q, lmfc_pulse_d;
  logic              aligned_q, aligned_d;
  logic              sysref_err_q, sysref_err_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [MISS_W-1:0] miss_q, miss_d;

  logic [LMFC_W-1:0] cnt_next;
  logic [MISS_W:0]   miss_inc;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lmfc_cnt_q   <= '0;
      lmfc_pulse_q <= 1'b0;
      aligned_q    <= 1'b0;
      sysref_err_q <= 1'b0;
      err_cnt_q    <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      lmfc_cnt_q   <= lmfc_cnt_d;
      lmfc_pulse_q <= lmfc_pulse_d;
      aligned_q    <= aligned_d;
      sysref_err_q <= sysref_err_d;
      err_cnt_q    <= err_cnt_d;
      miss_q       <= miss_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lmfc_cnt_d   = lmfc_cnt_q;
    sysref_err_d = 1'b0;
    err_cnt_d    = err_cnt_q;
    miss_d       = miss_q;
    cnt_next     = (lmfc_cnt_q == P_M1) ? '0 : lmfc_cnt_q + LMFC_W'(1);
    miss_inc     = {1'b0, miss_q} + (MISS_W + 1)'(1);

    case (state_q)
      IDLE: begin
        lmfc_cnt_d = '0;
        if (edge_det) begin
          state_d = ALIGNED;
        end
      end
      ALIGNED: begin
        lmfc_cnt_d = cnt_next;
        if (edge_det) begin
          if (lmfc_cnt_q == P_M1) begin
            miss_d = '0;
          end else begin
            sysref_err_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            if (lmfc_if.realign_en) begin
              lmfc_cnt_d = '0;
              miss_d     = '0;
            end else if (miss_inc >= THRESH) begin
              state_d    = IDLE;
              lmfc_cnt_d = '0;
              miss_d     = '0;
            end else begin
              miss_d = miss_inc[MISS_W-1:0];
            end
          end
        end
      end
      default: begin
        state_d    = IDLE;
        lmfc_cnt_d = '0;
      end
    endcase

    // Clear overrides the counters only; the drop decision above already used the old miss count.
    if (lmfc_if.clr_err) begin
      err_cnt_d = '0;
      miss_d    = '0;
    end

    aligned_d    = (state_d == ALIGNED);
    lmfc_pulse_d = (state_d == ALIGNED) && (lmfc_cnt_d == '0);
  end

  assign lmfc_if.lmfc_cnt   = lmfc_cnt_q;
  assign lmfc_if.lmfc_pulse = lmfc_pulse_q;
  assign lmfc_if.aligned    = aligned_q;
  assign lmfc_if.sysref_err = sysref_err_q;
  assign lmfc_if.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_sysref_lmfc_align.sv
// Directed/randomized bench for sysref_lmfc_align against an anchor-time LMFC reference model.
module tb_sysref_lmfc_align;

  localparam int F          = 4;
  localparam int K          = 32;
  localparam int ERR_THRESH = 3;
  localparam int P          = (K * F) / 4;

  logic clock = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  sysref_lmfc_align_if u_if ();

  sysref_lmfc_align #(
    .F          (F),
    .K          (K),
    .ERR_THRESH (ERR_THRESH)
  ) u_dut (
    .clock   (clock),
    .rst_n   (rst_n),
    .lmfc_if (u_if)
  );

  always #5 clock = ~clock;

  // Model: while aligned, LMFC phase at cycle n is (n - anchor) mod P.
  bit m_al;
  int m_anchor;
  int m_n;
  int m_errcnt;
  int m_miss;
  bit m_prev;
  bit m_err;

  function automatic int exp_cnt();
    return m_al ? ((m_n - m_anchor) % P) : 0;
  endfunction

  task automatic model_reset();
    m_al = 1'b0; m_anchor = 0; m_n = 0; m_errcnt = 0; m_miss = 0;
    m_prev = 1'b1; m_err = 1'b0;
  endtask

  task automatic model_update();
    bit ed;
    int cur;
    ed     = u_if.sysref && !m_prev;
    m_prev = u_if.sysref;
    m_err  = 1'b0;
    cur    = exp_cnt();
    if (!m_al) begin
      if (ed) begin
        m_al = 1'b1;
        m_anchor = m_n + 1;
      end
    end else if (ed) begin
      if (cur == P - 1) begin
        m_miss = 0;
      end else begin
        m_err = 1'b1;
        m_errcnt = (m_errcnt < 255) ? m_errcnt + 1 : 255;
        if (u_if.realign_en) begin
          m_anchor = m_n + 1;
          m_miss = 0;
        end else if (m_miss + 1 >= ERR_THRESH) begin
          m_al = 1'b0;
          m_miss = 0;
        end else begin
          m_miss = m_miss + 1;
        end
      end
    end
    if (u_if.clr_err) begin
      m_errcnt = 0;
      m_miss = 0;
    end
    m_n = m_n + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    int c;
    c = exp_cnt();
    chk({tag, ".lmfc_cnt"},   32'(u_if.lmfc_cnt),   32'(c));
    chk({tag, ".lmfc_pulse"}, 32'(u_if.lmfc_pulse), 32'(m_al && c == 0));
    chk({tag, ".aligned"},    32'(u_if.aligned),    32'(m_al));
    chk({tag, ".sysref_err"}, 32'(u_if.sysref_err), 32'(m_err));
    chk({tag, ".err_cnt"},    32'(u_if.err_cnt),    32'(m_errcnt));
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
    check_all("step");
  endtask

  // Wait until the LMFC phase equals ph, then raise SYSREF for width cycles.
  task automatic edge_at(input int ph, input int width);
    int guard;
    guard = 0;
    while (exp_cnt() != ph && guard < 3 * P) begin
      step();
      guard++;
    end
    if (guard >= 3 * P) begin
      checks++;
      failures++;
      $error("FAIL edge_at_timeout observed_phase=%0d expected_phase=%0d", exp_cnt(), ph);
    end
    u_if.sysref = 1'b1;
    repeat (width) step();
    u_if.sysref = 1'b0;
    step();
  endtask

  task automatic clear_pulse();
    u_if.clr_err = 1'b1;
    step();
    u_if.clr_err = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    u_if.sysref = 1'b1;
    u_if.realign_en = 1'b1;
    u_if.clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // SYSREF held high across reset release: no edge.
    repeat (100) step();
    chk("held_high.aligned", 32'(u_if.aligned), 32'd0);
    u_if.sysref = 1'b0;
    step();

    // Periodic edges on the LMFC boundary.
    edge_at(0, 1);
    chk("first_edge.aligned", 32'(u_if.aligned), 32'd1);
    for (int i = 0; i < 4; i++) edge_at(P - 1, $urandom_range(1, 3));
    chk("periodic.err_cnt", 32'(u_if.err_cnt), 32'd0);

    // One edge five cycles late with realign enabled.
    edge_at(4, 1);
    for (int i = 0; i < 3; i++) edge_at(P - 1, 1);
    chk("late.err_cnt", 32'(u_if.err_cnt), 32'd1);

    // Three consecutive misses drop alignment; next edge realigns.
    u_if.realign_en = 1'b0;
    clear_pulse();
    for (int i = 0; i < 3; i++) edge_at(i % P, 1);
    chk("drop.aligned", 32'(u_if.aligned), 32'd0);
    chk("drop.err_cnt", 32'(u_if.err_cnt), 32'd3);
    edge_at(0, 1);
    chk("realign.aligned", 32'(u_if.aligned), 32'd1);

    // Miss, miss, hit, miss, miss: alignment survives.
    clear_pulse();
    edge_at($urandom_range(0, P - 2), 1);
    edge_at($urandom_range(0, P - 2), 1);
    edge_at(P - 1, 1);
    edge_at($urandom_range(0, P - 2), 1);
    edge_at($urandom_range(0, P - 2), 1);
    chk("interleave.aligned", 32'(u_if.aligned), 32'd1);
    chk("interleave.err_cnt", 32'(u_if.err_cnt), 32'd4);

    // Long SYSREF on the boundary: single edge, no error.
    edge_at(P - 1, 40);
    chk("long_pulse.err_cnt", 32'(u_if.err_cnt), 32'd4);

    // Randomized mix of phases, realign mode and clears.
    for (int i = 0; i < 40; i++) begin
      u_if.realign_en = 1'($urandom_range(0, 1));
      u_if.clr_err = ($urandom_range(0, 7) == 0);
      if (!m_al) edge_at(0, $urandom_range(1, 2));
      else if ($urandom_range(0, 1) == 1) edge_at(P - 1, $urandom_range(1, 3));
      else edge_at($urandom_range(0, P - 2), $urandom_range(1, 3));
      u_if.clr_err = 1'b0;
    end

    // Saturation of the error counter.
    u_if.realign_en = 1'b1;
    if (!m_al) edge_at(0, 1);
    for (int i = 0; i < 300; i++) edge_at($urandom_range(0, P - 2), 1);
    chk("saturate.err_cnt", 32'(u_if.err_cnt), 32'd255);

    // Clear coincident with a misaligned edge.
    while (exp_cnt() != 3) step();
    u_if.sysref = 1'b1;
    u_if.clr_err = 1'b1;
    step();
    u_if.sysref = 1'b0;
    u_if.clr_err = 1'b0;
    chk("clr_coinc.sysref_err", 32'(u_if.sysref_err), 32'd1);
    chk("clr_coinc.err_cnt", 32'(u_if.err_cnt), 32'd0);
    step();

    // Asynchronous reset mid-count.
    repeat (10) step();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clock);
    #1;
    check_all("in_rst");
    rst_n = 1'b1;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
